// File: rtl/fadd_arbiter.sv
// Two-requester arbiter sharing one combinational single-precision adder,
// followed by a STAGES-deep result pipeline with a shared response bus.

module fadd (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] y_o,
    output logic        ovf_o
);
    logic        sa, sb, nan_a, nan_b, inf_a, inf_b, swap, sbig, sub;
    logic [7:0]  ea_eff, eb_eff, ebig, esml, d;
    logic [23:0] ma, mb, mbig, msml;
    logic [49:0] ext;
    logic [26:0] mbig27, msml27, norm;
    logic [27:0] sum;
    logic [9:0]  e, lz, sh;
    logic [31:0] pre;
    logic        g, rs, rnd;

    always_comb begin
        sa     = a_i[31];
        sb     = b_i[31];
        nan_a  = (a_i[30:23] == 8'hFF) && (a_i[22:0] != '0);
        nan_b  = (b_i[30:23] == 8'hFF) && (b_i[22:0] != '0);
        inf_a  = (a_i[30:23] == 8'hFF) && (a_i[22:0] == '0);
        inf_b  = (b_i[30:23] == 8'hFF) && (b_i[22:0] == '0);
        ea_eff = (a_i[30:23] == '0) ? 8'd1 : a_i[30:23];
        eb_eff = (b_i[30:23] == '0) ? 8'd1 : b_i[30:23];
        ma     = {a_i[30:23] != '0, a_i[22:0]};
        mb     = {b_i[30:23] != '0, b_i[22:0]};
        swap   = b_i[30:0] > a_i[30:0];
        sbig   = swap ? sb : sa;
        ebig   = swap ? eb_eff : ea_eff;
        mbig   = swap ? mb : ma;
        esml   = swap ? ea_eff : eb_eff;
        msml   = swap ? ma : mb;
        sub    = sa ^ sb;
        d      = ebig - esml;

        // Aligned smaller operand keeps guard and round bits plus a sticky bit.
        mbig27 = {mbig, 3'b000};
        ext    = {msml, 26'b0} >> d;
        if (d > 8'd26) begin
            msml27 = {26'b0, |msml};
        end else begin
            msml27 = {ext[49:24], |ext[23:0]};
        end
        sum = sub ? ({1'b0, mbig27} - {1'b0, msml27})
                  : ({1'b0, mbig27} + {1'b0, msml27});

        lz = 10'd27;
        for (int unsigned i = 0; i < 27; i++) begin
            if (sum[i]) lz = 10'(26 - i);
        end

        // Left normalisation stops at exponent 1 so tiny results become denormals.
        e    = {2'b00, ebig};
        sh   = '0;
        norm = '0;
        if (sum[27]) begin
            norm = {sum[27:2], sum[1] | sum[0]};
            e    = e + 10'd1;
        end else begin
            sh   = (lz < (e - 10'd1)) ? lz : (e - 10'd1);
            norm = sum[26:0] << sh;
            e    = e - sh;
        end

        g   = norm[2];
        rs  = norm[1] | norm[0];
        rnd = g & (rs | norm[3]);
        pre = {(norm[26] ? e[8:0] : 9'd0), norm[25:3]} + {31'b0, rnd};

        y_o   = '0;
        ovf_o = 1'b0;
        if (nan_a || nan_b || (inf_a && inf_b && sub)) begin
            y_o = 32'h7FC0_0000;
        end else if (inf_a) begin
            y_o = a_i;
        end else if (inf_b) begin
            y_o = b_i;
        end else if (sum == '0) begin
            y_o = {sa & sb, 31'b0};
        end else if (pre[31:23] >= 9'd255) begin
            y_o   = {sbig, 8'hFF, 23'b0};
            ovf_o = 1'b1;
        end else begin
            y_o = {sbig, pre[30:0]};
        end
    end
endmodule

module fadd_arbiter #(
    parameter int unsigned STAGES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_x1,
    input  logic [31:0] req0_x2,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_x1,
    input  logic [31:0] req1_x2,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp_y,
    output logic        rsp_ovf,
    output logic        busy
);
    logic                    last_grant_q, last_grant_d;
    logic [STAGES-1:0]       vld_q, tag_q, ovf_q;
    logic [STAGES-1:0][31:0] y_q;
    logic                    gnt0, gnt1, xfer0, xfer1;
    logic [31:0]             op_x1, op_x2, sum_y;
    logic                    sum_ovf;
    logic                    s1_vld_d, s1_tag_d, s1_ovf_d;
    logic [31:0]             s1_y_d;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!stall) begin
            if (req0_valid && req1_valid) begin
                gnt0 = last_grant_q;
                gnt1 = ~last_grant_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
        req0_ready   = gnt0 & rstn;
        req1_ready   = gnt1 & rstn;
        xfer0        = req0_valid & req0_ready;
        xfer1        = req1_valid & req1_ready;
        op_x1        = gnt1 ? req1_x1 : req0_x1;
        op_x2        = gnt1 ? req1_x2 : req0_x2;
        last_grant_d = last_grant_q;
        if (xfer0) last_grant_d = 1'b0;
        if (xfer1) last_grant_d = 1'b1;
    end

    fadd u_fadd (
        .a_i   (op_x1),
        .b_i   (op_x2),
        .y_o   (sum_y),
        .ovf_o (sum_ovf)
    );

    always_comb begin
        s1_vld_d = xfer0 | xfer1;
        s1_tag_d = xfer1;
        s1_y_d   = s1_vld_d ? sum_y : '0;
        s1_ovf_d = s1_vld_d & sum_ovf;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant_q <= 1'b1;
            vld_q        <= '0;
            tag_q        <= '0;
            ovf_q        <= '0;
            y_q          <= '0;
        end else if (!stall) begin
            last_grant_q <= last_grant_d;
            vld_q[0]     <= s1_vld_d;
            tag_q[0]     <= s1_tag_d;
            ovf_q[0]     <= s1_ovf_d;
            y_q[0]       <= s1_y_d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
                ovf_q[i] <= ovf_q[i-1];
                y_q[i]   <= y_q[i-1];
            end
        end
    end

    assign rsp_y      = y_q[STAGES-1];
    assign rsp_ovf    = ovf_q[STAGES-1];
    assign rsp0_valid = vld_q[STAGES-1] & ~tag_q[STAGES-1] & ~stall;
    assign rsp1_valid = vld_q[STAGES-1] &  tag_q[STAGES-1] & ~stall;
    assign busy       = |vld_q;
endmodule

// File: tb/tb_fadd_arbiter.sv
// Bench for fadd_arbiter: constant vector table, directed corner sequences and
// random traffic checked against a queue-based model using real arithmetic.
module tb_fadd_arbiter;
    localparam int unsigned STAGES = 2;

    logic        clk = 1'b0;
    logic        rstn, stall;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_x1, req0_x2, req1_x1, req1_x2;
    logic        rsp0_valid, rsp1_valid, rsp_ovf, busy;
    logic [31:0] rsp_y;

    int n_vec   = 0;
    int n_err   = 0;
    int rsp_cnt = 0;

    always #5 clk = ~clk;

    fadd_arbiter #(.STAGES(STAGES)) dut (
        .clk(clk), .rstn(rstn), .stall(stall),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x1(req0_x1), .req0_x2(req0_x2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x1(req1_x1), .req1_x2(req1_x2),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_y(rsp_y), .rsp_ovf(rsp_ovf),
        .busy(busy)
    );

    typedef struct {
        bit          tag;
        logic [31:0] y;
        bit          ovf;
        int unsigned age;
    } ent_t;
    ent_t q[$];
    bit   last_g;

    typedef struct {
        bit          who;
        logic [31:0] x1, x2, y;
        bit          ovf;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic real f2r(input logic [31:0] b);
        real r;
        if (b[30:23] == 8'd0) r = real'(b[22:0]) * (2.0 ** (-149.0));
        else r = real'({1'b1, b[22:0]}) * (2.0 ** real'(int'(b[30:23]) - 150));
        if (b[31]) r = -r;
        return r;
    endfunction

    // Round an exact double to single precision (nearest-even); bit 32 = overflow.
    function automatic logic [32:0] d2f(input logic [63:0] d);
        int          e, sh;
        logic [52:0] sig;
        logic [63:0] t;
        logic [31:0] mag;
        bit          g, st;
        if (d[62:52] == 11'd0) return {1'b0, d[63], 31'b0};
        e   = int'(d[62:52]) - 1023;
        sig = {1'b1, d[51:0]};
        if (e >= -126) begin
            mag = (32'(e + 127) << 23) | {9'b0, sig[51:29]};
            g   = sig[28];
            st  = |sig[27:0];
            if (g && (st || sig[29])) mag = mag + 32'd1;
            if (mag >= 32'h7F80_0000) return {1'b1, d[63], 31'h7F80_0000};
            return {1'b0, d[63], mag[30:0]};
        end
        sh = -e - 97;
        if (sh >= 55) return {1'b0, d[63], 31'b0};
        t   = {11'b0, sig};
        mag = 32'(t >> sh);
        g   = t[sh-1];
        st  = (t & ((64'd1 << (sh - 1)) - 64'd1)) != 64'd0;
        if (g && (st || mag[0])) mag = mag + 32'd1;
        return {1'b0, d[63], mag[30:0]};
    endfunction

    function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        bit na, nb, ia, ib;
        na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        ia = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        ib = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        if (na || nb || (ia && ib && (a[31] != b[31]))) return {1'b0, 32'h7FC0_0000};
        if (ia) return {1'b0, a};
        if (ib) return {1'b0, b};
        return d2f($realtobits(f2r(a) + f2r(b)));
    endfunction

    // One clock cycle: compare against the model mid-cycle, then advance it at the edge.
    task automatic tick();
        bit          eg0, eg1, ev0, ev1;
        logic [32:0] r;
        @(negedge clk);
        if (!rstn) begin
            q.delete();
            last_g = 1'b1;
        end
        eg0 = 0;
        eg1 = 0;
        if (rstn && !stall) begin
            if (req0_valid && req1_valid) begin
                eg1 = !last_g;
                eg0 = last_g;
            end else begin
                eg0 = req0_valid;
                eg1 = req1_valid;
            end
        end
        ev0 = 0;
        ev1 = 0;
        if (q.size() > 0 && q[0].age == STAGES) begin
            ev0 = !stall && !q[0].tag;
            ev1 = !stall && q[0].tag;
            check("rsp_y", rsp_y, q[0].y);
            check("rsp_ovf", 32'(rsp_ovf), 32'(q[0].ovf));
        end
        check("req0_ready", 32'(req0_ready), 32'(eg0));
        check("req1_ready", 32'(req1_ready), 32'(eg1));
        check("rsp0_valid", 32'(rsp0_valid), 32'(ev0));
        check("rsp1_valid", 32'(rsp1_valid), 32'(ev1));
        check("busy", 32'(busy), 32'(q.size() != 0));
        if (rsp0_valid || rsp1_valid) rsp_cnt++;
        @(posedge clk);
        if (!rstn) begin
            q.delete();
            last_g = 1'b1;
        end else if (!stall) begin
            for (int i = 0; i < q.size(); i++) q[i].age++;
            if (q.size() > 0 && q[0].age > STAGES) void'(q.pop_front());
            if (eg0 || eg1) begin
                r = eg1 ? ref_add(req1_x1, req1_x2) : ref_add(req0_x1, req0_x2);
                q.push_back('{tag: eg1, y: r[31:0], ovf: r[32], age: 1});
                last_g = eg1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; req0_valid = 0; req1_valid = 0; stall = 0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0: return {1'($urandom), 8'hFF, ($urandom_range(0, 1) == 0) ? 23'd0 : 23'($urandom)};
            1: return {1'($urandom), 8'hFE, 23'($urandom)};
            2: return {1'($urandom), 8'h00, 23'($urandom)};
            3: return {1'($urandom), 31'd0};
            default: return $urandom();
        endcase
    endfunction

    task automatic rnd_pair(output logic [31:0] a, output logic [31:0] b);
        a = rnd_op();
        case ($urandom_range(0, 3))
            0: b = a ^ 32'h8000_0000 ^ 32'($urandom_range(0, 3));
            1: b = {1'($urandom), a[30:23] ^ 8'($urandom_range(0, 3)), 23'($urandom)};
            default: b = rnd_op();
        endcase
    endtask

    vec_t vt[$];
    int   c0;

    initial begin
        vt = '{
            '{0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 0},
            '{1, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 0},
            '{0, 32'h3F00_0000, 32'h3F80_0000, 32'h3FC0_0000, 0},
            '{1, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 1},
            '{0, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 0},
            '{1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 0},
            '{0, 32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 0},
            '{1, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 0},
            '{0, 32'h0040_0000, 32'h0040_0000, 32'h0080_0000, 0},
            '{1, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 0},
            '{0, 32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 0},
            '{1, 32'h4049_0FDB, 32'hC049_0FDB, 32'h0000_0000, 0},
            '{0, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 0},
            '{1, 32'h3F80_0000, 32'h3380_0001, 32'h3F80_0001, 0}
        };

        // Reset state, with requests pending to show ready is held low.
        rstn = 0; stall = 0; req0_valid = 1; req1_valid = 1;
        req0_x1 = 32'h3F80_0000; req0_x2 = 32'h3F80_0000;
        req1_x1 = 32'h3F00_0000; req1_x2 = 32'h3F80_0000;
        q.delete(); last_g = 1'b1;
        #2;
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_ready1", 32'(req1_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_y", rsp_y, 32'd0);
        check("rst_rsp_ovf", 32'(rsp_ovf), 32'd0);
        @(posedge clk); #1;
        tick();
        rstn = 1;
        #1;
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
        check("post_rst_rsp_y", rsp_y, 32'd0);

        // Both valid straight out of reset: requester 0 first, then 1.
        check("arb_first_r0", 32'(req0_ready), 32'd1);
        check("arb_first_r1", 32'(req1_ready), 32'd0);
        tick();
        #1;
        check("arb_second_r0", 32'(req0_ready), 32'd0);
        check("arb_second_r1", 32'(req1_ready), 32'd1);
        tick();
        req0_valid = 0; req1_valid = 0;
        #1;
        check("arb_rsp0", 32'(rsp0_valid), 32'd1);
        check("arb_rsp0_y", rsp_y, 32'h4000_0000);
        tick();
        #1;
        check("arb_rsp1", 32'(rsp1_valid), 32'd1);
        check("arb_rsp1_y", rsp_y, 32'h3FC0_0000);
        tick();
        tick();

        // Constant vector table, one operation at a time.
        foreach (vt[k]) begin
            req0_valid = !vt[k].who; req1_valid = vt[k].who;
            if (vt[k].who) begin req1_x1 = vt[k].x1; req1_x2 = vt[k].x2; end
            else begin req0_x1 = vt[k].x1; req0_x2 = vt[k].x2; end
            #1;
            check("vec_ready", 32'(vt[k].who ? req1_ready : req0_ready), 32'd1);
            tick();
            req0_valid = 0; req1_valid = 0;
            for (int s = 1; s < STAGES; s++) tick();
            #1;
            check("vec_rsp_valid", 32'(vt[k].who ? rsp1_valid : rsp0_valid), 32'd1);
            check("vec_rsp_y", rsp_y, vt[k].y);
            check("vec_rsp_ovf", 32'(rsp_ovf), 32'(vt[k].ovf));
            tick();
        end

        // Stall with an operation sitting in stage 1.
        req0_valid = 1; req0_x1 = 32'h3F80_0000; req0_x2 = 32'h4000_0000;
        tick();
        stall = 1; req1_valid = 1;
        for (int s = 0; s < 3; s++) begin
            #1;
            check("stall_ready", 32'({req0_ready, req1_ready}), 32'd0);
            check("stall_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
            check("stall_busy", 32'(busy), 32'd1);
            tick();
        end
        stall = 0; req0_valid = 0; req1_valid = 0;
        #1;
        check("release_rsp_early", 32'(rsp0_valid), 32'd0);
        tick();
        #1;
        check("release_rsp", 32'(rsp0_valid), 32'd1);
        check("release_rsp_y", rsp_y, 32'h4040_0000);
        tick();
        tick();

        // 100 back-to-back cycles with both requesters valid.
        do_reset();
        c0 = rsp_cnt;
        for (int i = 0; i < 100; i++) begin
            req0_valid = 1; req1_valid = 1;
            rnd_pair(req0_x1, req0_x2);
            rnd_pair(req1_x1, req1_x2);
            #1;
            check("alt_ready0", 32'(req0_ready), 32'(i % 2 == 0));
            check("alt_ready1", 32'(req1_ready), 32'(i % 2 == 1));
            tick();
        end
        req0_valid = 0; req1_valid = 0;
        for (int s = 0; s <= STAGES; s++) tick();
        check("alt_rsp_count", 32'(rsp_cnt - c0), 32'd100);

        // Reset while two operations are in flight.
        do_reset();
        req0_valid = 1; req0_x1 = 32'h3F80_0000; req0_x2 = 32'h3F80_0000;
        tick();
        req0_valid = 0; req1_valid = 1; req1_x1 = 32'h4000_0000; req1_x2 = 32'h4000_0000;
        tick();
        rstn = 0; req0_valid = 1; req1_valid = 1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
        check("midrst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        c0 = rsp_cnt;
        tick();
        tick();
        rstn = 1; req0_valid = 0; req1_valid = 0;
        for (int s = 0; s < 4; s++) tick();
        check("midrst_no_rsp", 32'(rsp_cnt - c0), 32'd0);
        req0_valid = 1; req1_valid = 1;
        #1;
        check("midrst_r0_wins", 32'(req0_ready), 32'd1);
        check("midrst_r1_loses", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 0; req1_valid = 0;
        for (int s = 0; s <= STAGES; s++) tick();

        // Random traffic with stalls.
        for (int i = 0; i < 800; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            stall      = ($urandom_range(0, 4) == 0);
            rnd_pair(req0_x1, req0_x2);
            rnd_pair(req1_x1, req1_x2);
            tick();
        end
        req0_valid = 0; req1_valid = 0; stall = 0;
        for (int s = 0; s <= STAGES; s++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
